// File: rtl/ramp_adc_pkg.sv
// rtl/ramp_adc_pkg.sv - shared types and constants for the ramp ADC sequencer
package ramp_adc_pkg;

   localparam int CODE_W = 8;
   localparam logic [CODE_W-1:0] CODE_MAX = '1;

   typedef logic [CODE_W-1:0] code_t;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      RAMP,
      DONE
   } state_t;

endpackage

// File: rtl/ramp_adc_ctrl_pwm_gen.sv
// rtl/ramp_adc_ctrl_pwm_gen.sv - free-running PWM with duty shadowed at period start
module pwm_gen #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] duty,
   output logic             pwm
);

   localparam logic [WIDTH-1:0] MAX = '1;

   logic [WIDTH-1:0] pwm_cnt;
   logic [WIDTH-1:0] pwm_duty;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pwm_cnt  <= '0;
         pwm_duty <= '0;
         pwm      <= 1'b0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
         // Duty only changes on the wrap, so no period is ever cut short.
         if (pwm_cnt == MAX) begin
            pwm_duty <= duty;
         end
         pwm <= (pwm_cnt < pwm_duty);
      end
   end

endmodule

// File: rtl/ramp_adc_ctrl_sync_ff.sv
// rtl/ramp_adc_ctrl_sync_ff.sv - multi-stage synchroniser for an asynchronous level input
module sync_ff #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [DEPTH-1:0] stages;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stages <= '0;
      end else begin
         stages <= {stages[DEPTH-2:0], d};
      end
   end

   assign q = stages[DEPTH-1];

endmodule

// File: rtl/ramp_adc_ctrl.sv
// rtl/ramp_adc_ctrl.sv - start/settle/ramp/done sequencer for the ramp DAC with PWM of the result
module ramp_adc_ctrl
   import ramp_adc_pkg::*;
#(
   parameter int WIDTH         = CODE_W,
   parameter int SETTLE_CYCLES = 4,
   parameter int SYNC_STAGES   = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             cont,
   input  logic             cmp,
   output logic [WIDTH-1:0] dac_code,
   output logic             busy,
   output logic [WIDTH-1:0] result,
   output logic             result_valid,
   output logic             ovf,
   output logic             pwm
);

   localparam logic [WIDTH-1:0] MAX         = '1;
   localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
   localparam logic [1:0]       SYNC_LAG    = 2'(SYNC_STAGES);

   state_t           state;
   logic [7:0]       settle_cnt;
   logic [1:0]       lag_cnt;
   logic [WIDTH-1:0] ref_code;
   logic             cmp_s;

   sync_ff #(
      .DEPTH(SYNC_STAGES)
   ) u_cmp_sync (
      .clk  (clk),
      .reset(reset),
      .d    (cmp),
      .q    (cmp_s)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         dac_code     <= '0;
         result       <= '0;
         ref_code     <= '0;
         settle_cnt   <= '0;
         lag_cnt      <= '0;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         ovf          <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         case (state)
            IDLE: begin
               dac_code <= '0;
               if (start) begin
                  state      <= SETTLE;
                  settle_cnt <= SETTLE_LOAD;
                  busy       <= 1'b1;
               end
            end
            SETTLE: begin
               dac_code <= '0;
               if (settle_cnt == 8'd0) begin
                  state    <= RAMP;
                  ref_code <= '0;
                  lag_cnt  <= '0;
               end else begin
                  settle_cnt <= settle_cnt - 1'b1;
               end
            end
            RAMP: begin
               if (dac_code != MAX) begin
                  dac_code <= dac_code + 1'b1;
               end
               // ref_code trails dac_code by the synchroniser depth so it names
               // the code that produced the cmp_s seen this cycle.
               if (lag_cnt == SYNC_LAG) begin
                  if (ref_code != MAX) begin
                     ref_code <= ref_code + 1'b1;
                  end
               end else begin
                  lag_cnt <= lag_cnt + 1'b1;
               end
               if (cmp_s) begin
                  result       <= ref_code;
                  ovf          <= 1'b0;
                  result_valid <= 1'b1;
                  dac_code     <= '0;
                  state        <= DONE;
               end else if (ref_code == MAX) begin
                  result       <= MAX;
                  ovf          <= 1'b1;
                  result_valid <= 1'b1;
                  dac_code     <= '0;
                  state        <= DONE;
               end
            end
            DONE: begin
               dac_code <= '0;
               if (cont) begin
                  state      <= SETTLE;
                  settle_cnt <= SETTLE_LOAD;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   pwm_gen #(
      .WIDTH(WIDTH)
   ) u_pwm (
      .clk  (clk),
      .reset(reset),
      .duty (result),
      .pwm  (pwm)
   );

endmodule

// File: tb/tb_ramp_adc_ctrl.sv
// tb/tb_ramp_adc_ctrl.sv - directed self-checking bench for ramp_adc_ctrl
module tb_ramp_adc_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       cont = 1'b0;
   logic       cmp;
   logic [7:0] dac_code;
   logic       busy;
   logic [7:0] result;
   logic       result_valid;
   logic       ovf;
   logic       pwm;

   logic       trip_en = 1'b0;
   logic [7:0] trip_code = 8'd0;

   int checks = 0;
   int errors = 0;

   // Comparator model: trips once the DAC reaches the trip code.
   assign cmp = trip_en && (dac_code >= trip_code);

   always #5 clk = ~clk;

   ramp_adc_ctrl #(
      .WIDTH        (8),
      .SETTLE_CYCLES(4),
      .SYNC_STAGES  (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .cont        (cont),
      .cmp         (cmp),
      .dac_code    (dac_code),
      .busy        (busy),
      .result      (result),
      .result_valid(result_valid),
      .ovf         (ovf),
      .pwm         (pwm)
   );

   // Reference PWM: counter phase and duty as seen by an external observer.
   logic [7:0] m_cnt;
   logic [7:0] m_duty;
   logic       m_pwm;
   int         pwm_err = 0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_cnt  <= 8'd0;
         m_duty <= 8'd0;
         m_pwm  <= 1'b0;
      end else begin
         m_pwm <= (m_cnt < m_duty);
         if (m_cnt == 8'hFF) m_duty <= result;
         m_cnt <= m_cnt + 8'd1;
      end
   end

   always @(negedge clk) begin
      if (reset && (pwm !== m_pwm)) pwm_err++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic run_conv(input logic en, input logic [7:0] code, input bit inject,
                           output int busy_n, output int rv_n,
                           output logic [7:0] res_rv, output logic ovf_rv,
                           output logic [7:0] dac_pre, output logic [7:0] dac_rv);
      trip_en   = en;
      trip_code = code;
      busy_n    = 0;
      rv_n      = 0;
      res_rv    = 8'd0;
      ovf_rv    = 1'b0;
      dac_pre   = 8'd0;
      dac_rv    = 8'd0;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (busy && busy_n < 2000) begin
         if (result_valid) begin
            rv_n++;
            res_rv = result;
            ovf_rv = ovf;
            dac_rv = dac_code;
         end else begin
            dac_pre = dac_code;
         end
         busy_n++;
         start = inject && (busy_n == 2 || busy_n == 20);
         @(negedge clk);
      end
      start = 1'b0;
      check("conv_timeout", busy_n >= 2000, 0);
   endtask

   task automatic count_high(input int cycles, output int hi);
      hi = 0;
      for (int i = 0; i < cycles; i++) begin
         if (pwm) hi++;
         @(negedge clk);
      end
   endtask

   int         bn, rv, n, drops, hi, hi_before, quiet;
   logic [7:0] rs, dp, da, r1, r2;
   logic       ov;

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check("rst_dac", dac_code, 0);
      check("rst_busy", busy, 0);
      check("rst_result", result, 0);
      check("rst_rv", result_valid, 0);
      check("rst_ovf", ovf, 0);
      check("rst_pwm", pwm, 0);
      reset = 1'b1;

      quiet = 0;
      for (int i = 0; i < 600; i++) begin
         if (dac_code != 0 || pwm || busy || result_valid) quiet++;
         @(negedge clk);
      end
      check("idle_quiet", quiet, 0);

      // Nominal trip at 100
      run_conv(1'b1, 8'd100, 1'b0, bn, rv, rs, ov, dp, da);
      check("trip100_busy", bn, 108);
      check("trip100_rv", rv, 1);
      check("trip100_result", rs, 100);
      check("trip100_ovf", ov, 0);

      // No trip: saturate
      run_conv(1'b0, 8'd0, 1'b0, bn, rv, rs, ov, dp, da);
      check("notrip_busy", bn, 263);
      check("notrip_rv", rv, 1);
      check("notrip_result", rs, 255);
      check("notrip_ovf", ov, 1);
      check("notrip_dac_max", dp, 255);
      check("notrip_dac_done", da, 0);

      // start pulses while busy are ignored
      run_conv(1'b1, 8'd40, 1'b1, bn, rv, rs, ov, dp, da);
      check("inject_busy", bn, 48);
      check("inject_rv", rv, 1);
      check("inject_result", rs, 40);
      repeat (5) @(negedge clk);
      check("inject_idle", busy, 0);

      // Continuous mode: 40 then 60
      cont = 1'b1; trip_en = 1'b1; trip_code = 8'd40;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0; rv = 0; drops = 0; r1 = 8'd0; r2 = 8'd0;
      while (rv < 2 && n < 1000) begin
         if (!busy) drops++;
         if (result_valid) begin
            rv++;
            if (rv == 1) begin
               r1 = result;
               trip_code = 8'd60;
            end else begin
               r2 = result;
            end
         end else if (rv == 1) begin
            cont = 1'b0;
         end
         n++;
         @(negedge clk);
      end
      cont = 1'b0;
      check("cont_count", rv, 2);
      check("cont_first", r1, 40);
      check("cont_second", r2, 60);
      check("cont_no_gap", drops, 0);
      check("cont_end_idle", busy, 0);

      // PWM: duty 0, then 64 taking effect at the wrap, then 255
      run_conv(1'b1, 8'd0, 1'b0, bn, rv, rs, ov, dp, da);
      trip_en = 1'b0;
      check("zero_result", rs, 0);
      repeat (600) @(negedge clk);
      count_high(256, hi);
      check("pwm_duty0", hi, 0);

      run_conv(1'b1, 8'd64, 1'b0, bn, rv, rs, ov, dp, da);
      trip_en = 1'b0;
      check("pwm64_result", rs, 64);
      hi_before = 0; n = 0;
      do begin
         if (pwm) hi_before++;
         n++;
         @(negedge clk);
      end while (m_cnt != 8'd1 && n < 300);
      check("pwm64_hold_old", hi_before, 0);
      count_high(256, hi);
      check("pwm64_high", hi, 64);
      count_high(256, hi);
      check("pwm64_high_again", hi, 64);

      run_conv(1'b0, 8'd0, 1'b0, bn, rv, rs, ov, dp, da);
      repeat (600) @(negedge clk);
      count_high(256, hi);
      check("pwm255_high", hi, 255);

      // Reset in the middle of RAMP
      trip_en = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (dac_code != 8'd50 && n < 500) begin
         n++;
         @(negedge clk);
      end
      check("midramp_reach50", dac_code, 50);
      reset = 1'b0;
      #1;
      check("midrst_dac", dac_code, 0);
      check("midrst_busy", busy, 0);
      check("midrst_result", result, 0);
      check("midrst_ovf", ovf, 0);
      check("midrst_pwm", pwm, 0);
      rv = 0;
      repeat (3) begin
         @(negedge clk);
         if (result_valid) rv++;
      end
      reset = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (result_valid) rv++;
      end
      check("midrst_no_rv", rv, 0);
      check("midrst_result_held", result, 0);
      check("midrst_idle", busy, 0);

      run_conv(1'b1, 8'd30, 1'b0, bn, rv, rs, ov, dp, da);
      check("trip30_busy", bn, 38);
      check("trip30_rv", rv, 1);
      check("trip30_result", rs, 30);
      check("trip30_ovf", ov, 0);

      check("pwm_model", pwm_err, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ramp_adc_ctrl.md
Name: ramp_adc_ctrl

Overview:
Sequencer for the on-chip 8-bit ramp DAC in the temperature-to-PWM path.
- On `start` it drives the DAC code up from 0 and watches the analog comparator.
- It captures the code at which the comparator trips and presents it as the conversion result.
- It drives a glitch-free PWM output whose duty cycle is the last result.
- It replaces the free-running ramp counter with a start/settle/ramp/done controller. It also supports single-shot or continuous conversion.

Parameters:
- WIDTH, 8, DAC code, result and PWM counter width.
- SETTLE_CYCLES, 4, cycles DAC code is held at 0 before ramping (range 1..255).
- SYNC_STAGES, 2, comparator synchroniser depth (range 2..3).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset. Reset is asserted when 0; assertion is asynchronous and deassertion is synchronised externally.
- start  input  1  single-cycle request to begin a conversion; sampled only in IDLE.
- cont  input  1  continuous mode; when 1, DONE returns to SETTLE instead of IDLE.
- cmp  input  1  comparator output, asynchronous to clk.
- dac_code  output  WIDTH  code to ramp DAC, registered.
- busy  output  1  high in SETTLE, RAMP and DONE.
- result  output  WIDTH  last captured code, held until the next DONE.
- result_valid  output  1  one-cycle pulse in DONE.
- ovf  output  1  set in DONE if no trip occurred (result = MAX), else cleared in DONE.
- pwm  output  1  PWM, period 2^WIDTH cycles.

Behaviour:
Reset (reset=0), asynchronous:
- state=IDLE.
- dac_code, result, ref_code, pwm_cnt, pwm_duty, settle_cnt and the sync flops all =0.
- busy=0, result_valid=0, ovf=0, pwm=0.

Comparator input:
- cmp passes through SYNC_STAGES flops to give cmp_s. No other use of raw cmp.

State IDLE:
- dac_code=0.
- start=1 → SETTLE, with settle_cnt=SETTLE_CYCLES-1.

State SETTLE:
- dac_code=0.
- Decrement settle_cnt; at 0 → RAMP, with dac_code=0 and ref_code=0.
- start is ignored in every state other than IDLE.

State RAMP, each cycle:
- dac_code increments, saturating at MAX=2^WIDTH-1.
- ref_code tracks dac_code delayed by SYNC_STAGES cycles. It holds 0 for the first SYNC_STAGES RAMP cycles, then increments and keeps incrementing while dac_code sits at MAX. Net effect: ref_code = code that produced the cmp_s being sampled.
- cmp_s=1 → result=ref_code, ovf=0, → DONE.
- Otherwise, ref_code==MAX → result=MAX, ovf=1, → DONE.
- Trip takes priority over reaching MAX in the same cycle.
- cmp_s already 1 on the first RAMP cycle → result=0.

State DONE (one cycle):
- result_valid=1 and dac_code=0.
- Next state: SETTLE (settle_cnt reloaded) if cont=1, else IDLE.
- cont is sampled only in DONE.

PWM:
- pwm_cnt free-runs, wrapping MAX→0.
- pwm = (pwm_cnt < pwm_duty), registered.
- pwm_duty loads result only on the cycle pwm_cnt==MAX, so the new duty takes effect at period start. No partial periods.
- duty 0 → pwm constantly 0; duty MAX → high 255 of 256 cycles.

Reset mid-operation:
- Abort any state immediately to reset values. No result_valid is produced.

Conversion latency:
- From start to result_valid: 1 + SETTLE_CYCLES + (trip code + SYNC_STAGES + 1) cycles.

Decomposition:
- Package ramp_adc_pkg holds:
  - state enum typedef (IDLE, SETTLE, RAMP, DONE);
  - localparam CODE_MAX;
  - a code_t typedef of WIDTH bits.
- Sub-module: sync_ff, parameterised depth, async active-low reset, used for cmp.
- The PWM generator is a natural second sub-module, pwm_gen (counter, duty shadow register, comparator).
- The FSM stays in the top level.

Test Plan:
- Reset: drive reset=0 mid-stream → all outputs 0 immediately. After release, IDLE holds with dac_code=0 and pwm=0 for more than 512 cycles without start.
- Nominal trip: SETTLE_CYCLES=4; bench sets cmp=1 combinationally when dac_code≥100 → result=100, ovf=0, result_valid a single pulse. busy lasts 4+100+2+2 cycles after start is registered.
- No trip: cmp held 0 → result=255, ovf=1, dac_code reaches 255 and holds until DONE. Then dac_code=0.
- start while busy: pulse start during SETTLE and during RAMP → ignored; exactly one result_valid. cont=1 with trip at 40 then 60 → consecutive results 40, 60 without new start.
- PWM update: result changes 0→64 mid-period → pwm stays 0 until pwm_cnt wraps. Then pwm is high exactly 64 of every 256 cycles. Duty 255 → 1 low cycle per period.
- Reset mid-RAMP: assert reset at dac_code=50 → result retains reset value 0, no result_valid. Next conversion trips correctly at 30.
